// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host scancode receiver with glitch filter and frame timeout
module ps2_scancode_rx #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic [7:0] scancode,
   output logic       valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic [FW-1:0] filt_cnt;
   logic          clk_filt;
   logic          clk_filt_d;
   logic          fall;
   logic          dat;
   logic [1:0]    state;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign dat     = dat_sync[1];
   assign fall    = clk_filt_d & ~clk_filt;
   assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

   // Sync and filter preset high so an idle bus never looks like a falling edge after reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         filt_cnt   <= '0;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clock};
         dat_sync   <= {dat_sync[0], ps2_data};
         clk_filt_d <= clk_filt;
         if (clk_sync[1] != clk_filt) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
               clk_filt <= clk_sync[1];
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state == IDLE || fall || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shift     <= 8'h00;
         par       <= 1'b0;
         scancode  <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         if (tmo_hit) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!dat) begin
                     state   <= DATA;
                     bit_cnt <= 4'd0;
                     shift   <= 8'h00;
                  end
               end
               DATA: begin
                  shift   <= {dat, shift[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par   <= dat;
                  state <= STOP;
               end
               default: begin
                  // Odd parity over data plus parity bit, and a high stop bit.
                  if ((^{shift, par}) && dat) begin
                     scancode <= shift;
                     valid    <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  bit_cnt <= 4'd0;
                  state   <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

   localparam int HALF    = 40;
   localparam int TIMEOUT = 200;

   typedef struct packed {
      logic       is_err;
      logic [7:0] code;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       ps2_clock;
   logic       ps2_data;
   logic [7:0] scancode;
   logic       valid;
   logic       frame_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;

   ps2_scancode_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_clock (ps2_clock),
      .ps2_data  (ps2_data),
      .scancode  (scancode),
      .valid     (valid),
      .frame_err (frame_err)
   );

   always #10 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      ev_t e;
      if (!reset && (valid || frame_err)) begin
         check_eq("exclusive", 32'(valid & frame_err), 32'd0);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", 32'({valid, frame_err}), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("pulse_kind", 32'(frame_err), 32'(e.is_err));
            if (e.is_err) begin
               check_eq("code_held", 32'(scancode), 32'(last_good));
            end else begin
               check_eq("code", 32'(scancode), 32'(e.code));
               last_good = e.code;
            end
         end
      end
   end

   task automatic send_bit(input logic d, input bit glitch);
      ps2_data = d;
      if (glitch) begin
         repeat (HALF / 2) @(posedge clock);
         #2 ps2_clock = 1'b0;
         repeat (2) @(posedge clock);
         #2 ps2_clock = 1'b1;
         repeat (HALF / 2 - 2) @(posedge clock);
      end else begin
         repeat (HALF) @(posedge clock);
      end
      #2 ps2_clock = 1'b0;
      repeat (HALF) @(posedge clock);
      #2 ps2_clock = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit(par_ok ? ~^b : ^b, glitch);
      send_bit(1'b1, glitch);
      ps2_data = 1'b1;
   endtask

   task automatic push_ev(input logic is_err, input logic [7:0] code);
      ev_t e;
      e.is_err = is_err;
      e.code   = code;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clock);
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      ps2_clock = 1'b1;
      ps2_data  = 1'b1;
      repeat (5) @(posedge clock);
      @(negedge clock);
      check_eq("rst_scancode", 32'(scancode), 32'h00);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      #2 reset = 1'b0;
      repeat (50) @(posedge clock);

      push_ev(1'b0, 8'h1C);
      send_frame(8'h1C, 1'b1, 1'b0);
      wait_drain("drain_1c");

      push_ev(1'b0, 8'hF0);
      push_ev(1'b0, 8'h1C);
      send_frame(8'hF0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0);
      wait_drain("drain_back_to_back");

      push_ev(1'b1, 8'h00);
      send_frame(8'h5A, 1'b0, 1'b0);
      wait_drain("drain_parity_err");
      check_eq("held_after_err", 32'(scancode), 32'h1C);

      push_ev(1'b1, 8'h00);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
      ps2_data = 1'b1;
      repeat (TIMEOUT + 10) @(posedge clock);
      wait_drain("drain_timeout");
      push_ev(1'b0, 8'h29);
      send_frame(8'h29, 1'b1, 1'b0);
      wait_drain("drain_after_timeout");

      push_ev(1'b0, 8'h1C);
      send_frame(8'h1C, 1'b1, 1'b1);
      wait_drain("drain_glitch");

      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      #2 reset = 1'b1;
      repeat (5) @(posedge clock);
      @(negedge clock);
      check_eq("midframe_rst_code", 32'(scancode), 32'h00);
      last_good = 8'h00;
      #2 reset = 1'b0;
      ps2_clock = 1'b1;
      ps2_data  = 1'b1;
      repeat (TIMEOUT + 100) @(posedge clock);
      check_eq("no_pulse_after_rst", 32'(exp_q.size()), 32'd0);
      push_ev(1'b0, 8'h45);
      send_frame(8'h45, 1'b1, 1'b0);
      wait_drain("drain_after_rst");

      repeat (20) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
